// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
//   Final pipeline stage. It owns the architectural register file, drives the
//   fetch redirect, counts retired instructions and holds the sticky halt
//   flag that ECALL/EBREAK raise.
//
// Ports
//   CLK, RESET           clock, synchronous active-high reset
//   WB_V                 instruction in WB is valid
//   WB_Cst               control store word ([0] LD_REG, [6] LD_PC, [7] DR_MUX)
//   WB_RES               ALU/load result
//   WB_PC_MUX            1: redirect to WB_Target_Address, 0: redirect to WB_NPC
//   WB_NPC               PC+4 of the instruction (also the link value)
//   WB_IR                instruction word
//   WB_Target_Address    branch/jump target
//   DE_SR1, DE_SR2       decode read addresses
//   DE_SR1/2_DATA        combinational read data with same-cycle write bypass
//   WB_DR                rd of the WB instruction
//   WB_LD_REG_V          WB instruction will write a non-zero rd
//   WB_FE_LD_PC          fetch PC load strobe
//   WB_FE_PC             fetch PC load value
//   WB_INSTRET           retired-instruction count
//   WB_HALT              sticky halt flag
// -----------------------------------------------------------------------------
module writeback #(
  parameter int XLEN  = 64,
  parameter int NREG  = 32,
  parameter int CNT_W = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             WB_V,
  input  logic [16:0]      WB_Cst,
  input  logic [XLEN-1:0]  WB_RES,
  input  logic             WB_PC_MUX,
  input  logic [XLEN-1:0]  WB_NPC,
  input  logic [31:0]      WB_IR,
  input  logic [XLEN-1:0]  WB_Target_Address,
  input  logic [4:0]       DE_SR1,
  input  logic [4:0]       DE_SR2,
  output logic [XLEN-1:0]  DE_SR1_DATA,
  output logic [XLEN-1:0]  DE_SR2_DATA,
  output logic [4:0]       WB_DR,
  output logic             WB_LD_REG_V,
  output logic             WB_FE_LD_PC,
  output logic [XLEN-1:0]  WB_FE_PC,
  output logic [CNT_W-1:0] WB_INSTRET,
  output logic             WB_HALT
);

  localparam logic [6:0]  OP_SYSTEM   = 7'b1110011;
  localparam logic [24:0] ECALL_BITS  = 25'h0000000;
  localparam logic [24:0] EBREAK_BITS = 25'h0002000;

  logic             ld_reg;
  logic             ld_pc;
  logic             dr_mux;
  logic             is_sys;
  logic             wr_en;
  logic [XLEN-1:0]  wr_data;
  logic [XLEN-1:0]  rf [NREG];
  logic [CNT_W-1:0] instret_q;
  logic             halt_q;
  logic             unused_cst;

  assign ld_reg     = WB_Cst[0];
  assign ld_pc      = WB_Cst[6];
  assign dr_mux     = WB_Cst[7];
  assign unused_cst = ^{WB_Cst[16:8], WB_Cst[5:1]};

  assign is_sys = (WB_IR[6:0] == OP_SYSTEM) &&
                  ((WB_IR[31:7] == ECALL_BITS) || (WB_IR[31:7] == EBREAK_BITS));

  assign WB_DR       = WB_IR[11:7];
  assign WB_LD_REG_V = WB_V & ld_reg & (WB_DR != 5'd0);

  // The halting instruction itself neither writes nor redirects, whatever its
  // control word says; once halted nothing more takes effect until reset.
  assign wr_en   = WB_LD_REG_V & ~RESET & ~halt_q & ~is_sys;
  assign wr_data = dr_mux ? WB_NPC : WB_RES;

  // Not-taken branches still strobe with WB_NPC so the memory-stage stall
  // is released.
  assign WB_FE_LD_PC = WB_V & ld_pc & ~halt_q & ~RESET & ~is_sys;
  assign WB_FE_PC    = WB_PC_MUX ? WB_Target_Address : WB_NPC;

  always_comb begin
    DE_SR1_DATA = '0;
    if (DE_SR1 != 5'd0) begin
      if (wr_en && (WB_DR == DE_SR1)) DE_SR1_DATA = wr_data;
      else                            DE_SR1_DATA = rf[DE_SR1];
    end
  end

  always_comb begin
    DE_SR2_DATA = '0;
    if (DE_SR2 != 5'd0) begin
      if (wr_en && (WB_DR == DE_SR2)) DE_SR2_DATA = wr_data;
      else                            DE_SR2_DATA = rf[DE_SR2];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[WB_DR] <= wr_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      instret_q <= '0;
      halt_q    <= 1'b0;
    end else if (WB_V && !halt_q) begin
      instret_q <= instret_q + CNT_W'(1);
      if (is_sys) halt_q <= 1'b1;
    end
  end

  assign WB_INSTRET = instret_q;
  assign WB_HALT    = halt_q;

endmodule

// File: tb/tb_writeback.sv
module tb_writeback;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WB_V;
  logic [16:0] WB_Cst;
  logic [63:0] WB_RES;
  logic        WB_PC_MUX;
  logic [63:0] WB_NPC;
  logic [31:0] WB_IR;
  logic [63:0] WB_Target_Address;
  logic [4:0]  DE_SR1, DE_SR2;
  logic [63:0] DE_SR1_DATA, DE_SR2_DATA;
  logic [4:0]  WB_DR;
  logic        WB_LD_REG_V, WB_FE_LD_PC;
  logic [63:0] WB_FE_PC, WB_INSTRET;
  logic        WB_HALT;

  // Narrow-counter instance sharing the same stimulus; exercises wrap-around.
  logic [63:0] s_sr1, s_sr2, s_fe_pc;
  logic [4:0]  s_dr;
  logic        s_ld_reg_v, s_fe_ld, s_halt;
  logic [3:0]  s_instret;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  logic [63:0] m_regs [32];
  logic [63:0] m_cnt;
  bit          m_halt;

  always #5 CLK = ~CLK;

  writeback dut (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_Cst(WB_Cst), .WB_RES(WB_RES),
    .WB_PC_MUX(WB_PC_MUX), .WB_NPC(WB_NPC), .WB_IR(WB_IR),
    .WB_Target_Address(WB_Target_Address), .DE_SR1(DE_SR1), .DE_SR2(DE_SR2),
    .DE_SR1_DATA(DE_SR1_DATA), .DE_SR2_DATA(DE_SR2_DATA), .WB_DR(WB_DR),
    .WB_LD_REG_V(WB_LD_REG_V), .WB_FE_LD_PC(WB_FE_LD_PC), .WB_FE_PC(WB_FE_PC),
    .WB_INSTRET(WB_INSTRET), .WB_HALT(WB_HALT)
  );

  writeback #(.CNT_W(4)) dut_small (
    .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_Cst(WB_Cst), .WB_RES(WB_RES),
    .WB_PC_MUX(WB_PC_MUX), .WB_NPC(WB_NPC), .WB_IR(WB_IR),
    .WB_Target_Address(WB_Target_Address), .DE_SR1(DE_SR1), .DE_SR2(DE_SR2),
    .DE_SR1_DATA(s_sr1), .DE_SR2_DATA(s_sr2), .WB_DR(s_dr),
    .WB_LD_REG_V(s_ld_reg_v), .WB_FE_LD_PC(s_fe_ld), .WB_FE_PC(s_fe_pc),
    .WB_INSTRET(s_instret), .WB_HALT(s_halt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_sys(input logic [31:0] ir);
    return (ir[6:0] == 7'h73) && ((ir[31:7] == 25'h0) || (ir[31:7] == 25'h2000));
  endfunction

  // Reference: what a write this cycle would do, from the rules alone.
  function automatic bit m_we();
    return WB_V && WB_Cst[0] && (WB_IR[11:7] != 5'd0) && !RESET && !m_halt && !is_sys(WB_IR);
  endfunction

  function automatic logic [63:0] m_wdata();
    return WB_Cst[7] ? WB_NPC : WB_RES;
  endfunction

  function automatic logic [63:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 64'd0;
    if (m_we() && (WB_IR[11:7] == a)) return m_wdata();
    return m_regs[a];
  endfunction

  always @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
      m_cnt  = 64'd0;
      m_halt = 1'b0;
    end else begin
      if (m_we()) m_regs[WB_IR[11:7]] = m_wdata();
      if (WB_V && !m_halt) begin
        m_cnt = m_cnt + 64'd1;
        if (is_sys(WB_IR)) m_halt = 1'b1;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      chk("sr1_data", DE_SR1_DATA, m_read(DE_SR1));
      chk("sr2_data", DE_SR2_DATA, m_read(DE_SR2));
      chk("dr", {59'd0, WB_DR}, {59'd0, WB_IR[11:7]});
      chk("ld_reg_v", {63'd0, WB_LD_REG_V},
          {63'd0, WB_V && WB_Cst[0] && (WB_IR[11:7] != 5'd0)});
      chk("fe_ld_pc", {63'd0, WB_FE_LD_PC},
          {63'd0, WB_V && WB_Cst[6] && !m_halt && !RESET && !is_sys(WB_IR)});
      chk("fe_pc", WB_FE_PC, WB_PC_MUX ? WB_Target_Address : WB_NPC);
      chk("instret", WB_INSTRET, m_cnt);
      chk("instret_small", {60'd0, s_instret}, {60'd0, m_cnt[3:0]});
      chk("halt", {63'd0, WB_HALT}, {63'd0, m_halt});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input bit rst, input bit v, input logic [16:0] cst,
                       input logic [31:0] ir, input logic [63:0] res,
                       input bit pcmux, input logic [63:0] npc,
                       input logic [63:0] tgt, input logic [4:0] s1,
                       input logic [4:0] s2);
    RESET = rst; WB_V = v; WB_Cst = cst; WB_IR = ir; WB_RES = res;
    WB_PC_MUX = pcmux; WB_NPC = npc; WB_Target_Address = tgt;
    DE_SR1 = s1; DE_SR2 = s2;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
    m_cnt = 64'd0;
    m_halt = 1'b0;
    drive(1, 0, 17'h0, 32'h13, 64'd0, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    tick();
    chk_en = 1'b1;
    drive(1, 1, 17'h41, 32'h0000_00EF, 64'h55, 0, 64'h4, 64'h8, 5'd1, 5'd2);
    #1;
    chk("fe_ld_in_reset", {63'd0, WB_FE_LD_PC}, 64'd0);
    tick();

    // Reset state: every register reads zero.
    drive(0, 0, 17'h0, 32'h13, 64'd0, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      DE_SR1 = 5'(i);
      #1;
      chk("reset_reg", DE_SR1_DATA, 64'd0);
    end
    chk("reset_instret", WB_INSTRET, 64'd0);
    chk("reset_halt", {63'd0, WB_HALT}, 64'd0);

    // Write x5 with same-cycle bypass.
    tick();
    drive(0, 1, 17'h1, (32'd5 << 7) | 32'h33, 64'hDEAD_BEEF, 0, 64'h100, 64'h0, 5'd5, 5'd5);
    #1;
    chk("bypass_x5", DE_SR1_DATA, 64'hDEAD_BEEF);
    chk("bypass_x5_p2", DE_SR2_DATA, 64'hDEAD_BEEF);
    chk("ld_reg_v_x5", {63'd0, WB_LD_REG_V}, 64'd1);
    tick();
    drive(0, 0, 17'h0, 32'h13, 64'd0, 0, 64'd0, 64'd0, 5'd5, 5'd0);
    #1;
    chk("stored_x5", DE_SR1_DATA, 64'hDEAD_BEEF);
    chk("instret_1", WB_INSTRET, 64'd1);

    // Write to x0 is discarded but still retires.
    drive(0, 1, 17'h1, 32'h33, 64'h1234, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    #1;
    chk("ld_reg_v_x0", {63'd0, WB_LD_REG_V}, 64'd0);
    chk("read_x0", DE_SR1_DATA, 64'd0);
    tick();
    drive(0, 0, 17'h0, 32'h13, 64'd0, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    #1;
    chk("instret_2", WB_INSTRET, 64'd2);

    // JAL: redirect plus link write.
    drive(0, 1, 17'hC1, (32'd1 << 7) | 32'h6F, 64'hBAD, 1, 64'h104, 64'h200, 5'd0, 5'd0);
    #1;
    chk("jal_fe_ld", {63'd0, WB_FE_LD_PC}, 64'd1);
    chk("jal_fe_pc", WB_FE_PC, 64'h200);
    tick();
    drive(0, 1, 17'h40, 32'h0000_0063, 64'd0, 0, 64'h300, 64'h400, 5'd1, 5'd0);
    #1;
    chk("jal_x1", DE_SR1_DATA, 64'h104);
    chk("model_x1", m_regs[1], 64'h104);
    chk("nt_fe_ld", {63'd0, WB_FE_LD_PC}, 64'd1);
    chk("nt_fe_pc", WB_FE_PC, 64'h300);
    tick();

    // ECALL halts; subsequent write, count and redirect are blocked.
    drive(0, 1, 17'h0, 32'h0000_0073, 64'd0, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    tick();
    drive(0, 1, 17'h1, (32'd3 << 7) | 32'h33, 64'd77, 0, 64'd0, 64'd0, 5'd3, 5'd0);
    #1;
    chk("halt_set", {63'd0, WB_HALT}, 64'd1);
    chk("halt_instret", WB_INSTRET, 64'd5);
    chk("halt_no_bypass", DE_SR1_DATA, 64'd0);
    tick();
    drive(0, 1, 17'h40, 32'h63, 64'd0, 1, 64'h10, 64'h20, 5'd3, 5'd0);
    #1;
    chk("halt_x3", DE_SR1_DATA, 64'd0);
    chk("halt_instret2", WB_INSTRET, 64'd5);
    chk("halt_no_redirect", {63'd0, WB_FE_LD_PC}, 64'd0);
    tick();

    // Reset with a simultaneous write to x7.
    drive(1, 1, 17'h1, (32'd7 << 7) | 32'h33, 64'd5, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    tick();
    drive(0, 0, 17'h0, 32'h13, 64'd0, 0, 64'd0, 64'd0, 5'd7, 5'd5);
    #1;
    chk("rst_x7", DE_SR1_DATA, 64'd0);
    chk("rst_x5", DE_SR2_DATA, 64'd0);
    chk("rst_instret", WB_INSTRET, 64'd0);
    chk("rst_halt", {63'd0, WB_HALT}, 64'd0);

    // Counter wrap on the 4-bit instance.
    drive(0, 1, 17'h0, 32'h13, 64'd0, 0, 64'd0, 64'd0, 5'd0, 5'd0);
    for (int i = 0; i < 15; i++) tick();
    chk("small_all_ones", {60'd0, s_instret}, 64'd15);
    tick();
    chk("small_wrap", {60'd0, s_instret}, 64'd0);
    chk("wide_16", WB_INSTRET, 64'd16);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] ir;
      logic [4:0]  s1, s2;
      int r;
      r  = int'($urandom_range(0, 99));
      ir = (r < 3) ? 32'h0000_0073 : (r < 5) ? 32'h0010_0073 : $urandom;
      s1 = ($urandom_range(0, 2) == 0) ? ir[11:7] : 5'($urandom);
      s2 = ($urandom_range(0, 2) == 0) ? ir[11:7] : 5'($urandom);
      drive($urandom_range(0, 99) < 3, $urandom_range(0, 99) < 80, 17'($urandom),
            ir, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom},
            {$urandom, $urandom}, s1, s2);
      tick();
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
